// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned multiplier with per-transaction exact/approximate mode
// (low product columns OR-reduced, carry-free) and running error statistics.
module approx_mult_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_COLS = 4,
  parameter int unsigned PIPE        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [2*WIDTH-1:0] out_err,
  output logic              out_mode,
  input  logic              stat_clr,
  output logic [31:0]       stat_count,
  output logic [31:0]       stat_err_sum,
  output logic [2*WIDTH-1:0] stat_err_max
);

  localparam int unsigned PW = 2 * WIDTH;

  logic          advance;
  logic [PW-1:0] exact_c;
  logic [PW-1:0] high_c;
  logic [PW-1:0] low_c;
  logic [PW-1:0] approx_c;
  logic [PW-1:0] p_sel_c;
  logic [PW-1:0] err_sel_c;

  logic [PIPE-1:0] vld_q;
  logic [PIPE-1:0] mode_q;
  logic [PW-1:0]   p_q   [PIPE];
  logic [PW-1:0]   err_q [PIPE];

  logic        out_hs;
  logic [32:0] sum_ext_c;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Product generation: columns below APPROX_COLS are OR-reduced, the rest summed exactly.
  always_comb begin
    exact_c = PW'(in_a) * PW'(in_b);
    high_c  = '0;
    low_c   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if ((i + j) < APPROX_COLS) begin
          low_c = low_c | (PW'(in_a[i] & in_b[j]) << (i + j));
        end else begin
          high_c = high_c + (PW'(in_a[i] & in_b[j]) << (i + j));
        end
      end
    end
    // high_c has no bits below APPROX_COLS, so the OR merge loses nothing.
    approx_c  = high_c | low_c;
    p_sel_c   = in_mode ? approx_c : exact_c;
    err_sel_c = exact_c - p_sel_c;
  end

  // Pipeline stages: stage 0 captures the handshake, later stages shift on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int unsigned s = 0; s < PIPE; s++) begin
        p_q[s]   <= '0;
        err_q[s] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        p_q[0]    <= p_sel_c;
        err_q[0]  <= err_sel_c;
        mode_q[0] <= in_mode;
      end
      for (int unsigned s = 1; s < PIPE; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          p_q[s]    <= p_q[s-1];
          err_q[s]  <= err_q[s-1];
          mode_q[s] <= mode_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld_q[PIPE-1];
  assign out_p     = p_q[PIPE-1];
  assign out_err   = err_q[PIPE-1];
  assign out_mode  = mode_q[PIPE-1];

  assign out_hs    = out_valid && out_ready;
  assign sum_ext_c = {1'b0, stat_err_sum} + 33'(out_err);

  // Statistics; clear takes priority over a coincident handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count   <= '0;
      stat_err_sum <= '0;
      stat_err_max <= '0;
    end else if (stat_clr) begin
      stat_count   <= '0;
      stat_err_sum <= '0;
      stat_err_max <= '0;
    end else if (out_hs) begin
      if (stat_count != 32'hFFFF_FFFF) begin
        stat_count <= stat_count + 32'd1;
      end
      stat_err_sum <= sum_ext_c[32] ? 32'hFFFF_FFFF : sum_ext_c[31:0];
      if (out_err > stat_err_max) begin
        stat_err_max <= out_err;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: column-count product model,
// scoreboard queue, stats model, and directed literal vectors.
module tb_approx_mult_pipe;

  localparam int W  = 8;
  localparam int AC = 4;
  localparam int PP = 2;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [2*W-1:0] err;
    logic           mode;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, in_mode;
  logic [W-1:0]   in_a, in_b;
  logic           out_valid, out_ready, out_mode;
  logic [2*W-1:0] out_p, out_err, stat_err_max;
  logic           stat_clr;
  logic [31:0]    stat_count, stat_err_sum;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  res_t        exp_q[$];
  logic [31:0] m_count, m_sum;
  logic [2*W-1:0] m_max;
  logic        prev_stall;
  logic [2*W-1:0] prev_p, prev_err;
  logic        prev_mode;

  logic [W-1:0] va [6] = '{8'h0F, 8'hA5, 8'hFF, 8'h3C, 8'h81, 8'h07};
  logic [W-1:0] vb [6] = '{8'h0F, 8'h5A, 8'h01, 8'hC3, 8'h81, 8'h09};
  logic         vm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC), .PIPE(PP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_err(out_err), .out_mode(out_mode),
    .stat_clr(stat_clr), .stat_count(stat_count),
    .stat_err_sum(stat_err_sum), .stat_err_max(stat_err_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Product from column population counts: approximated columns contribute one bit if any pp is set.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    res_t r;
    int unsigned e, ap, cnt;
    e  = 32'(a) * 32'(b);
    ap = 0;
    for (int c = 0; c < 2*W-1; c++) begin
      cnt = 0;
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++)
          if (i + j == c && a[i] && b[j]) cnt++;
      if (c < AC) ap += (cnt != 0) ? (32'd1 << c) : 32'd0;
      else        ap += cnt << c;
    end
    r.p    = m ? (2*W)'(ap) : (2*W)'(e);
    r.err  = (2*W)'(e) - r.p;
    r.mode = m;
    return r;
  endfunction

  // Scoreboard, stall-hold and statistics checks on every falling edge.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_count = 0; m_sum = 0; m_max = 0; prev_stall = 0;
    end else begin
      check("stat_count", stat_count, m_count);
      check("stat_err_sum", stat_err_sum, m_sum);
      check("stat_err_max", 32'(stat_err_max), 32'(m_max));
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("hold out_valid", 32'(out_valid), 32'd1);
        check("hold out_p", 32'(out_p), 32'(prev_p));
        check("hold out_err", 32'(out_err), 32'(prev_err));
        check("hold out_mode", 32'(out_mode), 32'(prev_mode));
      end
      prev_stall = out_valid && !out_ready;
      prev_p = out_p; prev_err = out_err; prev_mode = out_mode;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected result", 32'(out_p), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          check("sb out_p", 32'(out_p), 32'(e.p));
          check("sb out_err", 32'(out_err), 32'(e.err));
          check("sb out_mode", 32'(out_mode), 32'(e.mode));
          if (!stat_clr) begin
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            m_sum = (64'(m_sum) + 64'(e.err) > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_sum + 32'(e.err);
            if (e.err > m_max) m_max = e.err;
          end
        end
      end
      if (stat_clr) begin
        m_count = 0; m_sum = 0; m_max = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_mode));
    end
  end

  // Presents operands; returns just after the accepting edge with in_valid still high.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int n = 0;
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2*W-1:0] p,
                            input logic [2*W-1:0] err, input logic m, input bit clr);
    int n = 0;
    if (clr) stat_clr = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " latency"}, 32'(n), 32'(PP));
    check({name, " out_p"}, 32'(out_p), 32'(p));
    check({name, " out_err"}, 32'(out_err), 32'(err));
    check({name, " out_mode"}, 32'(out_mode), 32'(m));
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    out_ready = 1'b1; stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_p", 32'(out_p), 32'd0);
    check("rst out_err", 32'(out_err), 32'd0);
    check("rst out_mode", 32'(out_mode), 32'd0);
    check("rst stat_count", stat_count, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed vectors
    send(8'h0F, 8'h0F, 1'b1); in_valid = 1'b0;
    expect_out("v0F", 16'd191, 16'd34, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 1'b1); in_valid = 1'b0;
    expect_out("vFF approx", 16'd64991, 16'd34, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 1'b0); in_valid = 1'b0;
    expect_out("vFF exact", 16'd65025, 16'd0, 1'b0, 1'b0);
    send(8'h03, 8'h03, 1'b1); in_valid = 1'b0;
    expect_out("v03", 16'd7, 16'd2, 1'b1, 1'b0);
    send(8'h01, 8'h80, 1'b1); in_valid = 1'b0;
    expect_out("v01x80", 16'd128, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("lit stat_count", stat_count, 32'd5);
    check("lit stat_err_sum", stat_err_sum, 32'd70);
    check("lit stat_err_max", 32'(stat_err_max), 32'd34);

    // Clear coincident with a handshake
    @(posedge clk); #1;
    send(8'h0F, 8'h0F, 1'b1); in_valid = 1'b0;
    expect_out("clr hs", 16'd191, 16'd34, 1'b1, 1'b1);
    @(negedge clk);
    check("clr stat_count", stat_count, 32'd0);
    check("clr stat_err_sum", stat_err_sum, 32'd0);
    check("clr stat_err_max", 32'(stat_err_max), 32'd0);

    // Back-to-back stream with a 3-cycle consumer stall
    @(posedge clk); #1;
    base = n_out;
    fork
      begin
        for (int k = 0; k < 6; k++) send(va[k], vb[k], vm[k]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall out_valid", 32'(out_valid), 32'd1);
        check("stall in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("stream results", 32'(n_out - base), 32'd6);
    check("stream queue empty", 32'(exp_q.size()), 32'd0);
    check("stream stat_count", stat_count, 32'd6);

    // Reset with two transactions in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b1);
    send(8'h33, 8'h44, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post-rst no result", 32'(seen), 32'd0);
    check("post-rst in_ready", 32'(in_ready), 32'd1);
    check("post-rst stat_count", stat_count, 32'd0);
    check("post-rst stat_err_sum", stat_err_sum, 32'd0);
    check("post-rst stat_err_max", 32'(stat_err_max), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
